// File: rtl/ucq_ctrl_n.sv
// Unit-clause queue controller: UCQ_in/UCQ_out FIFOs, conflict FSM, stall detect; UCQ_DEDUP_EN adds UCQ_in dedup.
// Latency: 1 cycle push-to-head (no bypass); bcp_halt, stall and eng_lit are combinational.
// Backpressure: pushes to a full queue are dropped (sticky overflow) unless a same-cycle pop frees a slot.
module ucq_ctrl_n #(
  parameter int LIT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int STALL_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_halt,
  input  logic                     imp_valid,
  input  logic [LIT_W-1:0]         imp_lit,
  input  logic                     uin_pop,
  output logic [LIT_W-1:0]         uin_lit,
  output logic                     uin_empty,
  output logic [$clog2(DEPTH):0]   uin_count,
  input  logic                     uout_push,
  input  logic [LIT_W-1:0]         uout_lit,
  output logic                     uout_full,
  output logic                     eng_valid,
  output logic [LIT_W-1:0]         eng_lit,
  input  logic                     eng_accept,
  input  logic                     eng_busy,
  input  logic                     eng_conflict,
  input  logic                     conflict_clr,
  output logic                     bcp_halt,
  output logic                     stall,
  output logic                     conflict,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STALL_CYC < 1) ? 1 : $clog2(STALL_CYC + 1);
  localparam logic [SW-1:0] STALL_C = SW'(STALL_CYC);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_CONFL = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [LIT_W-1:0] in_mem  [DEPTH];
  logic [LIT_W-1:0] out_mem [DEPTH];
  logic [AW:0]      in_wp, in_rp, out_wp, out_rp;
  logic [AW:0]      out_count;
  logic             in_full, out_empty;
  logic             in_push_req, in_push, in_pop;
  logic             out_push_req, out_push, out_pop;
  logic             imp_nz, dup_hit, neg_hit;
  logic             conflict_evt, flush, ovf_set;
  logic [SW-1:0]    idle_cnt;

  assign uin_count = in_wp - in_rp;
  assign uin_empty = (uin_count == '0);
  assign in_full   = (uin_count == CW'(DEPTH));
  assign out_count = out_wp - out_rp;
  assign out_empty = (out_count == '0);
  assign uout_full = (out_count == CW'(DEPTH));

  assign uin_lit = uin_empty ? '0 : in_mem[in_rp[AW-1:0]];
  assign eng_lit = out_empty ? '0 : -out_mem[out_rp[AW-1:0]];

  assign imp_nz = imp_valid && (imp_lit != '0);

`ifdef UCQ_DEDUP_EN
  logic [AW-1:0] off;
  // Only slots between read pointer and occupancy hold live literals.
  always_comb begin
    dup_hit = 1'b0;
    neg_hit = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - in_rp[AW-1:0];
      if ({1'b0, off} < uin_count) begin
        if (imp_lit == in_mem[i])  dup_hit = 1'b1;
        if (imp_lit == -in_mem[i]) neg_hit = 1'b1;
      end
    end
  end
`else
  assign dup_hit = 1'b0;
  assign neg_hit = 1'b0;
`endif

  assign conflict_evt = eng_conflict || (imp_nz && neg_hit);
  // Queues clear on the edge entering FLUSH and again while in FLUSH.
  assign flush = (state == S_FLUSH) || ((state == S_RUN) && conflict_evt);

  assign in_push_req  = imp_nz && !dup_hit && !flush;
  assign in_pop       = uin_pop && !uin_empty;
  assign in_push      = in_push_req && (!in_full || in_pop);

  assign eng_valid    = !out_empty && (state == S_RUN);
  assign out_push_req = uout_push && (uout_lit != '0) && !flush;
  assign out_pop      = eng_accept && eng_valid;
  assign out_push     = out_push_req && (!uout_full || out_pop);

  assign ovf_set = (in_push_req && !in_push) || (out_push_req && !out_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wp  <= '0;
      in_rp  <= '0;
      out_wp <= '0;
      out_rp <= '0;
    end else if (flush) begin
      in_wp  <= '0;
      in_rp  <= '0;
      out_wp <= '0;
      out_rp <= '0;
    end else begin
      if (in_push)  in_wp  <= in_wp + 1'b1;
      if (in_pop)   in_rp  <= in_rp + 1'b1;
      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wp[AW-1:0]]   <= imp_lit;
    if (out_push) out_mem[out_wp[AW-1:0]] <= uout_lit;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (conflict_evt) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_CONFL;
      S_CONFL: if (conflict_clr) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state == S_RUN) && out_empty && !uout_push && !imp_valid && !eng_busy) begin
      if (idle_cnt != STALL_C) idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // A new drop in the clearing cycle wins so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (conflict_clr) overflow <= 1'b0;
  end

  assign stall    = (idle_cnt == STALL_C) && !uout_push;
  assign conflict = (state == S_FLUSH) || (state == S_CONFL);
  assign bcp_halt = proc_halt || (uin_count >= CW'(AFULL_TH)) || (state != S_RUN);

endmodule

// File: doc/ucq_ctrl_n.md
UCQ_CTRL_N -- requirements
Module: ucq_ctrl_n

Interface
REQ-001 Parameter LIT_W, default 16: signed two's-complement literal width.
REQ-002 Parameter DEPTH, default 8, power of 2 and at least 2: entries per queue.
REQ-003 Parameter AFULL_TH, default DEPTH-2: UCQ_in occupancy at which halt asserts.
REQ-004 Parameter STALL_CYC, default 2: consecutive idle cycles before stall asserts.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- proc_halt  in  1  external halt request.
- imp_valid  in  1  engine implication push.
- imp_lit  in  LIT_W  implied literal.
- uin_pop  in  1  arbiter pops UCQ_in.
- uin_lit  out  LIT_W  UCQ_in head.
- uin_empty  out  1  UCQ_in empty.
- uin_count  out  $clog2(DEPTH)+1  UCQ_in occupancy.
- uout_push  in  1  arbiter pushes UCQ_out.
- uout_lit  in  LIT_W  pushed literal.
- uout_full  out  1  UCQ_out full.
- eng_valid  out  1  literal available to engine.
- eng_lit  out  LIT_W  negated UCQ_out head.
- eng_accept  in  1  engine consumes eng_lit.
- eng_busy  in  1  engine mid-operation.
- eng_conflict  in  1  engine conflict pulse.
- conflict_clr  in  1  software clears conflict.
- bcp_halt  out  1  halt to engine.
- stall  out  1  processor idle.
- conflict  out  1  conflict status.
- overflow  out  1  sticky dropped-push flag.

Function
REQ-006 UCQ_in and UCQ_out SHALL be independent DEPTH-entry FIFOs with registered storage, pointer wrap at DEPTH, and first-word latency of 1 cycle (no bypass).
REQ-007 A push to a full queue SHALL be dropped and SHALL set overflow, except when a pop occurs in the same cycle, in which case both the push and the pop complete.
REQ-008 A pop of an empty queue SHALL be ignored; a simultaneous push and pop on an empty queue SHALL perform only the push.
REQ-009 A push of literal 0 SHALL be dropped silently.
REQ-010 eng_lit SHALL equal the LIT_W-bit two's-complement negation of the UCQ_out head.
REQ-011 eng_valid SHALL be !UCQ_out empty && state==RUN.
REQ-012 eng_accept SHALL pop UCQ_out only when eng_valid is 1.
REQ-013 bcp_halt SHALL be combinational: proc_halt | (uin_count >= AFULL_TH) | (state != RUN).
REQ-014 FSM states:
- RUN to FLUSH on eng_conflict.
- FLUSH to CONFL unconditionally after 1 cycle.
- CONFL to RUN on conflict_clr.
- conflict_clr outside CONFL SHALL be ignored.
REQ-015 FLUSH SHALL empty both queues; all pushes in the FLUSH cycle are dropped; pushes in CONFL are accepted.
REQ-016 conflict SHALL be 1 exactly in states FLUSH and CONFL.
REQ-017 Idle counter: in RUN, increments (saturating at STALL_CYC) when UCQ_out is empty, !uout_push, !imp_valid and !eng_busy; otherwise clears to 0.
REQ-018 stall SHALL be (counter == STALL_CYC) && !uout_push.
REQ-019 overflow SHALL clear only on reset or on conflict_clr.

Reset
REQ-020 On rst_n low, immediately, asynchronously:
- both queues empty; state RUN; counter 0.
- outputs: uin_empty=1, uin_count=0, uout_full=0, eng_valid=0, uin_lit=0, eng_lit=0, stall=0, conflict=0, overflow=0, bcp_halt=proc_halt.
REQ-021 Reset mid-operation SHALL discard all queued literals.

Configuration
REQ-022 With UCQ_DEDUP_EN defined:
- an imp_lit equal to any valid UCQ_in entry SHALL be dropped without setting overflow;
- an imp_lit equal to the negation of any valid UCQ_in entry SHALL act as eng_conflict.
- Without the macro, every nonzero push follows REQ-007.

Verification
REQ-023 Push uout_lit 5 then -3; hold eng_accept=1 -> eng_lit=-5, then 3, on consecutive cycles; eng_valid=0 afterwards.
REQ-024 DEPTH=8: push 9 implications with no pop -> uin_count=8, overflow=1, bcp_halt=1 from count 6.
REQ-025 Full UCQ_in, same-cycle push 7 and pop -> count stays 8, overflow stays 0, 7 appears at the tail.
REQ-026 eng_conflict while 3 literals are queued -> conflict=1, both queues empty next cycle, bcp_halt=1; conflict_clr -> RUN, conflict=0.
REQ-027 All inputs idle in RUN -> stall=1 on the 2nd cycle; a uout_push in that cycle forces stall=0.
REQ-028 UCQ_DEDUP_EN: push 4, then 4 -> count 1; then push -4 -> conflict=1.
